// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline bus: decode fields and control going into EX, the registered
// EX-stage copy, and the load-use stall/bubble status coming back out.
interface id_ex_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [1:0]      id_alu_op;
  logic [3:0]      id_func;
  logic            id_alu_src;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic            id_mem_to_reg;
  logic            id_branch;
  logic            flush;
  logic            ext_stall;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [1:0]      ex_alu_op;
  logic [3:0]      ex_func;
  logic            ex_alu_src;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;
  logic            ex_branch;
  logic            stall_req;
  logic [CNT_W-1:0] bubble_cnt;

  // The decode stage drives the bus; the pipeline register sits on the slave side.
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_alu_op, id_func, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_branch, flush, ext_stall,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_func, ex_alu_src,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
           stall_req, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_alu_op, id_func, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_branch, flush, ext_stall,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_func, ex_alu_src,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch,
           stall_req, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on flush or hazard, downstream-stall hold and a saturating bubble counter.
module id_ex_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_pipe_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [1:0]      alu_op;
    logic [3:0]      func;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } ex_state_t;

  ex_state_t        ex_q, ex_d;
  ex_state_t        id_entry;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             hazard;

  // A load in EX whose destination feeds the instruction sitting in ID.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && bus.id_valid &&
             ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
              (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));
  end

  assign bus.stall_req = hazard & ~bus.flush;

  // An invalid ID slot loads as an all-zero entry so no stale control leaks into EX.
  always_comb begin
    id_entry = '0;
    if (bus.id_valid) begin
      id_entry.valid      = 1'b1;
      id_entry.pc         = bus.id_pc;
      id_entry.rs1_data   = bus.id_rs1_data;
      id_entry.rs2_data   = bus.id_rs2_data;
      id_entry.imm        = bus.id_imm;
      id_entry.rs1        = bus.id_rs1;
      id_entry.rs2        = bus.id_rs2;
      id_entry.rd         = bus.id_rd;
      id_entry.alu_op     = bus.id_alu_op;
      id_entry.func       = bus.id_func;
      id_entry.alu_src    = bus.id_alu_src;
      id_entry.mem_read   = bus.id_mem_read;
      id_entry.mem_write  = bus.id_mem_write;
      id_entry.reg_write  = bus.id_reg_write;
      id_entry.mem_to_reg = bus.id_mem_to_reg;
      id_entry.branch     = bus.id_branch;
    end
  end

  // Priority: downstream stall holds everything, then flush/hazard bubble, then load.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.ext_stall) begin
      if (bus.flush || hazard) begin
        ex_d = '0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d = id_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1_data   = ex_q.rs1_data;
  assign bus.ex_rs2_data   = ex_q.rs2_data;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_func       = ex_q.func;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed hazard/flush/stall/reset scenarios
// plus randomized traffic, all checked against a record-level reference model.
module tb_id_ex_pipe;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [1:0]  alu_op;
    logic [3:0]  func;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } id_rec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  alu_op;
    logic [3:0]  func;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } ex_rec_t;

  logic clk;
  logic rst;

  id_ex_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int failures  = 0;

  // Reference model state: what EX should hold and how many bubbles were counted.
  ex_rec_t exp_ex;
  int      exp_cnt;
  id_rec_t cur_id;
  logic    cur_flush;
  logic    cur_stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ex_rec_t id_to_ex(input id_rec_t id);
    ex_rec_t e;
    e = '0;
    if (id.valid) begin
      e.valid      = 1'b1;
      e.pc         = id.pc;
      e.rs1_data   = id.rs1_data;
      e.rs2_data   = id.rs2_data;
      e.imm        = id.imm;
      e.rs1        = id.rs1;
      e.rs2        = id.rs2;
      e.rd         = id.rd;
      e.alu_op     = id.alu_op;
      e.func       = id.func;
      e.alu_src    = id.alu_src;
      e.mem_read   = id.mem_read;
      e.mem_write  = id.mem_write;
      e.reg_write  = id.reg_write;
      e.mem_to_reg = id.mem_to_reg;
      e.branch     = id.branch;
    end
    return e;
  endfunction

  function automatic logic model_hazard(input id_rec_t id);
    return exp_ex.valid && exp_ex.mem_read && (exp_ex.rd != 5'd0) && id.valid &&
           ((id.use_rs1 && id.rs1 == exp_ex.rd) || (id.use_rs2 && id.rs2 == exp_ex.rd));
  endfunction

  function automatic logic model_stall_req();
    return model_hazard(cur_id) && !cur_flush;
  endfunction

  function automatic ex_rec_t read_ex();
    ex_rec_t e;
    e.valid      = bus.ex_valid;
    e.pc         = bus.ex_pc;
    e.rs1_data   = bus.ex_rs1_data;
    e.rs2_data   = bus.ex_rs2_data;
    e.imm        = bus.ex_imm;
    e.rs1        = bus.ex_rs1;
    e.rs2        = bus.ex_rs2;
    e.rd         = bus.ex_rd;
    e.alu_op     = bus.ex_alu_op;
    e.func       = bus.ex_func;
    e.alu_src    = bus.ex_alu_src;
    e.mem_read   = bus.ex_mem_read;
    e.mem_write  = bus.ex_mem_write;
    e.reg_write  = bus.ex_reg_write;
    e.mem_to_reg = bus.ex_mem_to_reg;
    e.branch     = bus.ex_branch;
    return e;
  endfunction

  function automatic id_rec_t rand_id();
    id_rec_t r;
    r.valid      = ($urandom_range(0, 4) != 0);
    r.pc         = $urandom;
    r.rs1_data   = $urandom;
    r.rs2_data   = $urandom;
    r.imm        = $urandom;
    r.rs1        = 5'($urandom_range(0, 3));
    r.rs2        = 5'($urandom_range(0, 3));
    r.rd         = 5'($urandom_range(0, 3));
    r.use_rs1    = 1'($urandom_range(0, 1));
    r.use_rs2    = 1'($urandom_range(0, 1));
    r.alu_op     = 2'($urandom_range(0, 2));
    r.func       = 4'($urandom_range(0, 15));
    r.alu_src    = 1'($urandom_range(0, 1));
    r.mem_read   = 1'($urandom_range(0, 1));
    r.mem_write  = 1'($urandom_range(0, 1));
    r.reg_write  = 1'($urandom_range(0, 1));
    r.mem_to_reg = 1'($urandom_range(0, 1));
    r.branch     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input id_rec_t id, input logic fl, input logic st);
    cur_id    = id;
    cur_flush = fl;
    cur_stall = st;
    bus.id_valid      = id.valid;
    bus.id_pc         = id.pc;
    bus.id_rs1_data   = id.rs1_data;
    bus.id_rs2_data   = id.rs2_data;
    bus.id_imm        = id.imm;
    bus.id_rs1        = id.rs1;
    bus.id_rs2        = id.rs2;
    bus.id_rd         = id.rd;
    bus.id_use_rs1    = id.use_rs1;
    bus.id_use_rs2    = id.use_rs2;
    bus.id_alu_op     = id.alu_op;
    bus.id_func       = id.func;
    bus.id_alu_src    = id.alu_src;
    bus.id_mem_read   = id.mem_read;
    bus.id_mem_write  = id.mem_write;
    bus.id_reg_write  = id.reg_write;
    bus.id_mem_to_reg = id.mem_to_reg;
    bus.id_branch     = id.branch;
    bus.flush         = fl;
    bus.ext_stall     = st;
    #1;
  endtask

  // One rising edge: the model applies the stall > flush/hazard > load rule.
  task automatic clock_edge();
    logic hz;
    @(posedge clk);
    hz = model_hazard(cur_id);
    if (!cur_stall) begin
      if (cur_flush || hz) begin
        exp_ex = '0;
        if (exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
      end else begin
        exp_ex = id_to_ex(cur_id);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ex  = '0;
    exp_cnt = 0;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ex_rec_t act;
    rst = 1'b1;
    exp_ex  = '0;
    exp_cnt = 0;
    drive(rand_id(), 1'b0, 1'b0);
    act = read_ex();
    tests_run++;
    if (act !== exp_ex) begin
      failures++;
      $display("[TB] FAIL reset_ex: got %h want %h", act, exp_ex);
    end
    tests_run++;
    if (bus.bubble_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_cnt: got %h want 0000", bus.bubble_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(rand_id(), 1'(i == 1), 1'b0);
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.stall_req !== 1'b0 || bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'h0000) begin
        failures++;
        $display("[TB] FAIL reset_hold: stall_req=%b ex_valid=%b cnt=%h want 0/0/0000",
                 bus.stall_req, bus.ex_valid, bus.bubble_cnt);
      end
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    id_rec_t lw, add;
    ex_rec_t act;
    int      cnt0;
    do_reset();
    lw = '0;
    lw.valid = 1'b1; lw.pc = 32'h0000_0100; lw.rs1 = 5'd2; lw.use_rs1 = 1'b1;
    lw.rd = 5'd5; lw.imm = 32'h10; lw.alu_src = 1'b1; lw.mem_read = 1'b1;
    lw.reg_write = 1'b1; lw.mem_to_reg = 1'b1;
    drive(lw, 1'b0, 1'b0);
    clock_edge();
    act = read_ex();
    tests_run++;
    if (act !== exp_ex) begin
      failures++;
      $display("[TB] FAIL load_use_lw: got %h want %h", act, exp_ex);
    end
    add = '0;
    add.valid = 1'b1; add.pc = 32'h0000_0104; add.rs1 = 5'd5; add.use_rs1 = 1'b1;
    add.rs2 = 5'd6; add.use_rs2 = 1'b1; add.rd = 5'd7; add.alu_op = 2'b10;
    add.func = 4'($urandom_range(0, 15)); add.reg_write = 1'b1;
    add.rs1_data = $urandom; add.rs2_data = $urandom;
    cnt0 = exp_cnt;
    drive(add, 1'b0, 1'b0);
    tests_run++;
    if (bus.stall_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_stall: got %b want 1", bus.stall_req);
    end
    clock_edge();
    tests_run++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'(cnt0 + 1) || read_ex() !== '0) begin
      failures++;
      $display("[TB] FAIL load_use_bubble: ex_valid=%b cnt=%h want 0/%h, ex=%h",
               bus.ex_valid, bus.bubble_cnt, 16'(cnt0 + 1), read_ex());
    end
    drive(add, 1'b0, 1'b0);
    tests_run++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_use_release: stall_req got %b want 0", bus.stall_req);
    end
    clock_edge();
    act = read_ex();
    tests_run++;
    if (act !== id_to_ex(add) || bus.ex_alu_op !== 2'b10 || bus.ex_func !== add.func) begin
      failures++;
      $display("[TB] FAIL load_use_add: got %h want %h", act, id_to_ex(add));
    end
  endtask

  task automatic test_rd_zero();
    id_rec_t lw0, user;
    do_reset();
    lw0 = '0;
    lw0.valid = 1'b1; lw0.mem_read = 1'b1; lw0.rd = 5'd0; lw0.mem_to_reg = 1'b1;
    drive(lw0, 1'b0, 1'b0);
    clock_edge();
    user = rand_id();
    user.valid = 1'b1; user.rs1 = 5'd0; user.use_rs1 = 1'b1; user.rs2 = 5'd0; user.use_rs2 = 1'b1;
    drive(user, 1'b0, 1'b0);
    tests_run++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rd_zero_stall: got %b want 0", bus.stall_req);
    end
    clock_edge();
    tests_run++;
    if (read_ex() !== id_to_ex(user) || bus.bubble_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rd_zero_load: ex=%h cnt=%h want ex=%h cnt=0000",
               read_ex(), bus.bubble_cnt, id_to_ex(user));
    end
  endtask

  task automatic test_flush_hazard();
    id_rec_t lw, user;
    int      cnt0;
    lw = rand_id();
    lw.valid = 1'b1; lw.mem_read = 1'b1; lw.rd = 5'd9;
    drive(lw, 1'b0, 1'b0);
    clock_edge();
    user = rand_id();
    user.valid = 1'b1; user.rs2 = 5'd9; user.use_rs2 = 1'b1;
    cnt0 = exp_cnt;
    drive(user, 1'b1, 1'b0);
    tests_run++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_hazard_stall: got %b want 0", bus.stall_req);
    end
    clock_edge();
    tests_run++;
    if (read_ex() !== '0 || bus.bubble_cnt !== 16'(cnt0 + 1)) begin
      failures++;
      $display("[TB] FAIL flush_hazard_bubble: ex=%h cnt=%h want zero/%h",
               read_ex(), bus.bubble_cnt, 16'(cnt0 + 1));
    end
  endtask

  task automatic test_ext_stall();
    id_rec_t a, b;
    ex_rec_t held;
    int      cnt0;
    a = rand_id();
    a.valid = 1'b1; a.mem_read = 1'b0;
    drive(a, 1'b0, 1'b0);
    clock_edge();
    held = id_to_ex(a);
    cnt0 = exp_cnt;
    b = rand_id();
    b.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(b, 1'(i == 1), 1'b1);
      clock_edge();
      tests_run++;
      if (read_ex() !== held || bus.bubble_cnt !== 16'(cnt0)) begin
        failures++;
        $display("[TB] FAIL ext_stall_hold%0d: ex=%h cnt=%h want ex=%h cnt=%h",
                 i, read_ex(), bus.bubble_cnt, held, 16'(cnt0));
      end
    end
    drive(b, 1'b0, 1'b0);
    clock_edge();
    tests_run++;
    if (read_ex() !== id_to_ex(b) || bus.bubble_cnt !== 16'(cnt0)) begin
      failures++;
      $display("[TB] FAIL ext_stall_release: ex=%h cnt=%h want ex=%h cnt=%h",
               read_ex(), bus.bubble_cnt, id_to_ex(b), 16'(cnt0));
    end
  endtask

  task automatic test_random();
    id_rec_t id;
    logic    fl, st, want_stall;
    for (int i = 0; i < 400; i++) begin
      id = rand_id();
      fl = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 5) == 0);
      drive(id, fl, st);
      want_stall = model_stall_req();
      tests_run++;
      if (bus.stall_req !== want_stall) begin
        failures++;
        $display("[TB] FAIL random_stall[%0d]: got %b want %b", i, bus.stall_req, want_stall);
      end
      clock_edge();
      tests_run++;
      if (read_ex() !== exp_ex || bus.bubble_cnt !== 16'(exp_cnt)) begin
        failures++;
        $display("[TB] FAIL random_ex[%0d]: ex=%h cnt=%h want ex=%h cnt=%h",
                 i, read_ex(), bus.bubble_cnt, exp_ex, 16'(exp_cnt));
      end
    end
  endtask

  task automatic test_async_reset();
    id_rec_t lw, user;
    drive(rand_id(), 1'b1, 1'b0);
    clock_edge();
    lw = rand_id();
    lw.valid = 1'b1; lw.mem_read = 1'b1; lw.rd = 5'd3; lw.reg_write = 1'b1; lw.branch = 1'b1;
    drive(lw, 1'b0, 1'b0);
    clock_edge();
    user = rand_id();
    user.valid = 1'b1; user.rs1 = 5'd3; user.use_rs1 = 1'b1;
    drive(user, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (read_ex() !== '0 || bus.bubble_cnt !== 16'h0000 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: ex=%h cnt=%h stall_req=%b want all zero",
               read_ex(), bus.bubble_cnt, bus.stall_req);
    end
    exp_ex  = '0;
    exp_cnt = 0;
    #1;
    rst = 1'b0;
    clock_edge();
    tests_run++;
    if (read_ex() !== id_to_ex(user) || bus.bubble_cnt !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL async_reset_resume: ex=%h cnt=%h want ex=%h cnt=0000",
               read_ex(), bus.bubble_cnt, id_to_ex(user));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CNT_MAX; i++) begin
      drive(rand_id(), 1'b1, 1'b0);
      clock_edge();
    end
    tests_run++;
    if (bus.bubble_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL saturation_reach: got %h want ffff", bus.bubble_cnt);
    end
    drive(rand_id(), 1'b1, 1'b0);
    clock_edge();
    tests_run++;
    if (bus.bubble_cnt !== 16'hFFFF || read_ex() !== '0) begin
      failures++;
      $display("[TB] FAIL saturation_hold: cnt=%h ex=%h want ffff/zero",
               bus.bubble_cnt, read_ex());
    end
  endtask

  initial begin
    rst       = 1'b1;
    exp_ex    = '0;
    exp_cnt   = 0;
    cur_id    = '0;
    cur_flush = 1'b0;
    cur_stall = 1'b0;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_flush_hazard();
    test_ext_stall();
    test_random();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter: XLEN, 32, datapath width of pc/operand/immediate fields.
REQ-002 Parameter: CNT_W, 16, width of bubble counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  ID holds a real instruction.
REQ-006 id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode datapath fields.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-008 id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2.
REQ-009 id_alu_op  in  2  ALU class (00 load/store, 01 branch, 10 R-type).
REQ-010 id_func  in  4  {funct7[5], funct3} for downstream ALU control decode.
REQ-011 id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control bits.
REQ-012 flush  in  1  taken branch/redirect; kill instruction entering EX.
REQ-013 ext_stall  in  1  downstream stall; EX register holds.
REQ-014 ex_* outputs  out  same widths as id_* counterparts (pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_op, func, six control bits)  registered EX-stage copy.
REQ-015 ex_valid  out  1  EX holds a real instruction.
REQ-016 stall_req  out  1  combinational load-use stall request to PC and IF/ID.
REQ-017 bubble_cnt  out  CNT_W  count of bubbles inserted.

Function
REQ-018 Hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-019 stall_req SHALL equal hazard & ~flush, combinationally; it does not depend on ext_stall.
REQ-020 Per rising edge, priority: ext_stall (hold all ex_* and ex_valid) > flush (bubble) > hazard (bubble) > load (copy all id_* to ex_*, ex_valid <= id_valid).
REQ-021 Bubble: ex_valid=0, all six control bits=0, ex_alu_op=2'b00, ex_func=4'b0000, ex_rd/rs1/rs2=0, all XLEN fields=0.
REQ-022 Load with id_valid=0 SHALL be treated as a bubble (all fields zeroed per REQ-021).
REQ-023 Latency: one cycle from id_* to ex_*; no internal queueing, single entry.
REQ-024 bubble_cnt SHALL increment by 1 on each edge where a bubble is written by flush or hazard (not by REQ-022, not while ext_stall), saturating at all-ones.
REQ-025 Hazard bubble lasts exactly one cycle: after the bubble, ex_mem_read=0 so hazard clears and the held ID instruction loads next edge.
REQ-026 ext_stall held over multiple cycles SHALL freeze ex_* and bubble_cnt unchanged; flush asserted only during ext_stall has no effect.
REQ-027 rd=0 never triggers hazard, even with mem_read set.

Reset
REQ-028 On rst assertion, immediately (no clock): all ex_* outputs 0, ex_valid=0, bubble_cnt=0.
REQ-029 rst asserted mid-stall or mid-hazard SHALL discard state; first edge after release performs a normal priority evaluation.
REQ-030 stall_req is 0 throughout reset (follows from ex_valid=0).

Verification
REQ-031 Load-use: EX holds lw x5 (mem_read=1, rd=5, valid); ID add with rs1=5, use_rs1=1 -> stall_req=1, next edge ex_valid=0, bubble_cnt=1; following edge add appears with ex_alu_op=10, ex_func matches.
REQ-032 rd=0: EX lw x0, ID uses rs1=0 -> stall_req=0, ID instruction loads next edge, bubble_cnt=0.
REQ-033 Flush with hazard: hazard present and flush=1 -> stall_req=0, bubble written, bubble_cnt increments by exactly 1.
REQ-034 ext_stall 3 cycles with flush pulsed in cycle 2 -> ex_* constant all 3 cycles, bubble_cnt unchanged; normal load on first edge after release.
REQ-035 Saturation: preload via 65535 flushes -> bubble_cnt=16'hFFFF; one more flush -> stays 16'hFFFF.
REQ-036 Async reset mid-cycle with ex_valid=1 -> ex_valid, controls, bubble_cnt read 0 before next clock edge.
